// File: rtl/proc_simd_mul_unit_pkg.sv
// Shared definitions for the iterative SIMD multiply unit: function codes,
// request/response field layout, FSM states and lane helpers.
package proc_SimdMulPkg;

  localparam int NBITS      = 32;
  localparam int LANE_NBITS = 8;
  localparam int NUM_LANES  = 4;

  localparam int REQ_NBITS  = 66;
  localparam int RESP_NBITS = 32;
  localparam int FN_MSB     = 65;
  localparam int FN_LSB     = 64;
  localparam int A_MSB      = 63;
  localparam int A_LSB      = 32;
  localparam int B_MSB      = 31;
  localparam int B_LSB      = 0;

  localparam logic [1:0] FN_MUL    = 2'b00;
  localparam logic [1:0] FN_MUL8   = 2'b01;
  localparam logic [1:0] FN_KMUL8  = 2'b10;
  localparam logic [1:0] FN_UKMUL8 = 2'b11;

  // Counter preload is the step count minus one
  localparam logic [5:0] MUL_STEPS_M1  = 6'd31;
  localparam logic [5:0] LANE_STEPS_M1 = 6'd7;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_CALC,
    STATE_DONE
  } state_t;

  // Magnitude of a two's-complement byte; -128 maps to 0x80 unsigned
  function automatic logic [7:0] mag8(input logic [7:0] x);
    return x[7] ? (~x + 8'd1) : x;
  endfunction

endpackage

// File: rtl/proc_simd_mul_unit_lane8.sv
// One 8-bit lane: shift-add multiplier with sign handling for KMUL8 and the
// per-function saturation mux applied to the final accumulator value.
module proc_SimdMulLane8
  import proc_SimdMulPkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       load_signed,
  input  logic       step,
  input  logic [1:0] fn,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  logic [15:0]        mcand;
  logic [15:0]        acc;
  logic [15:0]        acc_next;
  logic [7:0]         mplier;
  logic               neg;
  logic signed [15:0] sprod;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (load) begin
      mcand  <= {8'h00, load_signed ? mag8(a) : a};
      mplier <= load_signed ? mag8(b) : b;
      acc    <= '0;
      neg    <= load_signed & (a[7] ^ b[7]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Result is taken from the accumulator value the final step produces
  always_comb begin
    acc_next = mplier[0] ? (acc + mcand) : acc;
    sprod    = neg ? -$signed(acc_next) : $signed(acc_next);
    result   = sprod[7:0];
    case (fn)
      FN_KMUL8: begin
        if (sprod > 16'sd127)
          result = 8'h7F;
        else if (sprod < -16'sd128)
          result = 8'h80;
      end
      FN_UKMUL8: begin
        if (acc_next > 16'd255)
          result = 8'hFF;
      end
      default: result = sprod[7:0];
    endcase
  end

endmodule

// File: rtl/proc_simd_mul_unit.sv
// Iterative multiply unit for the X stage: FSM, shared step counter and the
// 32-bit low-word shift-add datapath, plus four 8-bit subword lanes.
module proc_simd_mul_unit
  import proc_SimdMulPkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [REQ_NBITS-1:0]  req_msg,
  output logic                  resp_val,
  input  logic                  resp_rdy,
  output logic [RESP_NBITS-1:0] resp_msg
);

  state_t            state;
  state_t            state_next;
  logic [5:0]        counter;
  logic [1:0]        fn_reg;
  logic [NBITS-1:0]  a_reg;
  logic [NBITS-1:0]  b_reg;
  logic [NBITS-1:0]  acc;
  logic [NBITS-1:0]  acc_next;
  logic [NBITS-1:0]  lane_result;
  logic [1:0]        req_fn;
  logic              req_fire;
  logic              resp_fire;
  logic              calc;
  logic              last_step;

  assign req_fn    = req_msg[FN_MSB:FN_LSB];
  assign req_fire  = req_val && req_rdy;
  assign resp_fire = resp_val && resp_rdy;
  assign calc      = (state == STATE_CALC);
  assign last_step = calc && (counter == 6'd0);
  assign acc_next  = b_reg[0] ? (acc + a_reg) : acc;

  always_ff @(posedge clk) begin
    if (reset)
      state <= STATE_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    case (state)
      STATE_IDLE: begin
        req_rdy = 1'b1;
        if (req_val)
          state_next = STATE_CALC;
      end
      STATE_CALC: begin
        if (counter == 6'd0)
          state_next = STATE_DONE;
      end
      STATE_DONE: begin
        resp_val = 1'b1;
        if (resp_fire)
          state_next = STATE_IDLE;
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  // Full-width datapath, counter and the registered response word
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= '0;
      fn_reg   <= FN_MUL;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      resp_msg <= '0;
    end else begin
      if (req_fire) begin
        fn_reg  <= req_fn;
        a_reg   <= req_msg[A_MSB:A_LSB];
        b_reg   <= req_msg[B_MSB:B_LSB];
        acc     <= '0;
        counter <= (req_fn == FN_MUL) ? MUL_STEPS_M1 : LANE_STEPS_M1;
      end else if (calc) begin
        acc     <= acc_next;
        a_reg   <= a_reg << 1;
        b_reg   <= b_reg >> 1;
        if (counter != 6'd0)
          counter <= counter - 6'd1;
      end
      if (last_step)
        resp_msg <= (fn_reg == FN_MUL) ? acc_next : lane_result;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    proc_SimdMulLane8 u_lane (
      .clk         (clk),
      .reset       (reset),
      .load        (req_fire),
      .load_signed (req_fn == FN_KMUL8),
      .step        (calc),
      .fn          (fn_reg),
      .a           (req_msg[A_LSB + i*LANE_NBITS +: LANE_NBITS]),
      .b           (req_msg[B_LSB + i*LANE_NBITS +: LANE_NBITS]),
      .result      (lane_result[i*LANE_NBITS +: LANE_NBITS])
    );
  end

endmodule

// File: tb/tb_proc_simd_mul_unit.sv
// Directed self-checking bench for proc_simd_mul_unit: per-function vectors,
// exact latency, backpressure and mid-operation reset.
module tb_proc_simd_mul_unit;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [65:0] req_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int checks;
  int errors;

  proc_simd_mul_unit dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_rdy  (req_rdy),
    .req_msg  (req_msg),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_msg (resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with resp_rdy high and check latency, stall and result
  task automatic applyStimulus(input string tag, input logic [1:0] fn,
                               input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [31:0] exp);
    int lat;
    bit rdy_low;
    resp_rdy = 1'b1;
    req_msg  = {fn, a, b};
    req_val  = 1'b1;
    checkOutput({tag, " req_rdy@T"}, {31'd0, req_rdy}, 32'd1);
    nextCycle();
    req_val = 1'b0;
    req_msg = {2'b11, 32'hDEADBEEF, 32'hA5A5A5A5};
    lat     = 1;
    rdy_low = 1'b1;
    while (!resp_val && lat < 100) begin
      if (req_rdy) rdy_low = 1'b0;
      nextCycle();
      lat++;
    end
    if (req_rdy) rdy_low = 1'b0;
    checkOutput({tag, " latency"}, lat, n + 1);
    checkOutput({tag, " req_rdy low"}, {31'd0, rdy_low}, 32'd1);
    checkOutput({tag, " result"}, resp_msg, exp);
    nextCycle();
    checkOutput({tag, " resp_val drop"}, {31'd0, resp_val}, 32'd0);
    checkOutput({tag, " req_rdy back"}, {31'd0, req_rdy}, 32'd1);
  endtask

  initial begin
    int lat;
    bit hold_ok;
    bit no_resp;
    logic [31:0] held;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    resp_rdy = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("reset req_rdy", {31'd0, req_rdy}, 32'd1);
    checkOutput("reset resp_val", {31'd0, resp_val}, 32'd0);
    checkOutput("reset resp_msg", resp_msg, 32'h0);
    reset = 1'b0;
    nextCycle();

    applyStimulus("MUL 7*6", 2'b00, 32'h00000007, 32'h00000006, 32, 32'h0000002A);
    applyStimulus("MUL ff*ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'h00000001);
    applyStimulus("MUL8", 2'b01, 32'h0210FF80, 32'h0310FF02, 8, 32'h06000100);
    applyStimulus("KMUL8", 2'b10, 32'h80807FFE, 32'h807F7F03, 8, 32'h7F807FFA);
    applyStimulus("UKMUL8", 2'b11, 32'h100EFF00, 32'h101101FF, 8, 32'hFFEEFF00);

    // Backpressure: response held while a second request waits
    resp_rdy = 1'b0;
    req_msg  = {2'b01, 32'h0210FF80, 32'h0310FF02};
    req_val  = 1'b1;
    nextCycle();
    req_msg  = {2'b01, 32'h11223344, 32'h02020202};
    lat = 1;
    while (!resp_val && lat < 100) begin
      nextCycle();
      lat++;
    end
    checkOutput("bp latency", lat, 32'd9);
    held    = resp_msg;
    checkOutput("bp result", held, 32'h06000100);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      if (!resp_val || req_rdy || resp_msg !== held) hold_ok = 1'b0;
    end
    checkOutput("bp hold", {31'd0, hold_ok}, 32'd1);
    resp_rdy = 1'b1;
    nextCycle();
    checkOutput("bp idle resp_val", {31'd0, resp_val}, 32'd0);
    checkOutput("bp idle req_rdy", {31'd0, req_rdy}, 32'd1);
    nextCycle();
    req_val = 1'b0;
    checkOutput("bp second accepted", {31'd0, req_rdy}, 32'd0);
    lat = 1;
    while (!resp_val && lat < 100) begin
      nextCycle();
      lat++;
    end
    checkOutput("bp second latency", lat, 32'd9);
    checkOutput("bp second result", resp_msg, 32'h22446688);
    nextCycle();

    // Reset in the middle of a MUL
    req_msg = {2'b00, 32'h12345678, 32'h9ABCDEF0};
    req_val = 1'b1;
    nextCycle();
    req_val = 1'b0;
    repeat (4) nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("rst req_rdy", {31'd0, req_rdy}, 32'd1);
    checkOutput("rst resp_val", {31'd0, resp_val}, 32'd0);
    checkOutput("rst resp_msg", resp_msg, 32'h0);
    no_resp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nextCycle();
      if (resp_val || !req_rdy) no_resp = 1'b0;
    end
    checkOutput("rst aborted", {31'd0, no_resp}, 32'd1);
    applyStimulus("MUL 3*5", 2'b00, 32'h00000003, 32'h00000005, 32, 32'h0000000F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
